// File: rtl/fft_r2_seq.sv
// fft_r2_seq: sequential in-place radix-2 DIT FFT over a valid/ready stream.
// Samples load in bit-reversed order. One butterfly per clock runs in place
// in a register array. Bins then stream out in natural order, with each
// stage scaled by 1/2 and saturated.
//
//   state     | meaning
//   S_LOAD    | accept N samples, write sample n to address bitrev(n)
//   S_COMPUTE | LOG2N stages x N/2 butterflies, one per cycle
//   S_UNLOAD  | present bin k from address k, advance on handshake
module fft_r2_seq #(
  parameter int N     = 8,
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int LOG2N = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [LOG2N-1:0]     out_index,
  output logic                 out_last,
  output logic                 busy
);
  localparam int  HALF   = N / 2;
  localparam int  CW     = LOG2N - 1;
  localparam int  SW     = $clog2(LOG2N);
  localparam int  PW     = DW + TW + 1;
  localparam int  AW     = DW + 2;
  localparam real PI     = 3.14159265358979323846;
  localparam real TSCALE = 2.0 ** (TW - 2);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t               state_q, state_d;
  logic [LOG2N-1:0]     cnt_q, cnt_d, cnt_nx;
  logic [CW-1:0]        bfly_q, bfly_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic signed [DW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [LOG2N-1:0]     out_index_q, out_index_d;
  logic                 ld_we, bf_we;

  logic signed [DW-1:0] mem_re_q [N];
  logic signed [DW-1:0] mem_im_q [N];
  logic signed [TW-1:0] tw_re [HALF];
  logic signed [TW-1:0] tw_im [HALF];

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    for (int i = 0; i < LOG2N; i++) bitrev[i] = v[LOG2N-1-i];
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] v);
    if (v[AW-1:DW-1] == '0 || v[AW-1:DW-1] == '1) return v[DW-1:0];
    else if (v[AW-1]) return {1'b1, {(DW-1){1'b0}}};
    else return {1'b0, {(DW-1){1'b1}}};
  endfunction

  // Twiddle ROM W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), rounded to nearest.
  for (genvar k = 0; k < HALF; k++) begin : g_tw
    localparam real ANG = 2.0 * PI * k / N;
    localparam real VRE = $cos(ANG) * TSCALE;
    localparam real VIM = -$sin(ANG) * TSCALE;
    localparam int  IRE = (VRE >= 0.0) ? $rtoi(VRE + 0.5) : -$rtoi(0.5 - VRE);
    localparam int  IIM = (VIM >= 0.0) ? $rtoi(VIM + 0.5) : -$rtoi(0.5 - VIM);
    assign tw_re[k] = TW'(IRE);
    assign tw_im[k] = TW'(IIM);
  end

  logic [LOG2N-1:0] c_ext, j_off, addr_p, addr_q;
  logic [SW:0]      stage_p1;
  logic [CW-1:0]    tw_k;

  // Butterfly addressing: top p = g*2^(s+1)+j, bottom q = p+2^s, k = j*N/2^(s+1).
  always_comb begin
    c_ext    = {1'b0, bfly_q};
    stage_p1 = {1'b0, stage_q} + 1'b1;
    j_off    = c_ext & ((LOG2N'(1) << stage_q) - LOG2N'(1));
    addr_p   = ((c_ext >> stage_q) << stage_p1) | j_off;
    addr_q   = addr_p | (LOG2N'(1) << stage_q);
    tw_k     = CW'(j_off << (SW'(CW) - stage_q));
  end

  logic signed [DW-1:0] a_re, a_im, b_re, b_im, p_re, p_im, q_re, q_im;
  logic signed [TW-1:0] w_re, w_im;
  logic signed [PW-1:0] prod_re, prod_im;
  logic signed [AW-1:0] t_re, t_im, sp_re, sp_im, sq_re, sq_im;

  // Butterfly datapath: t = b*W >>> (TW-2), then (a +/- t) >>> 1 with saturation.
  always_comb begin
    a_re    = mem_re_q[addr_p];
    a_im    = mem_im_q[addr_p];
    b_re    = mem_re_q[addr_q];
    b_im    = mem_im_q[addr_q];
    w_re    = tw_re[tw_k];
    w_im    = tw_im[tw_k];
    prod_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    prod_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    // |b*W| stays below 2^(DW+1), so DW+2 bits hold the sums without wrap.
    t_re    = AW'(prod_re >>> (TW - 2));
    t_im    = AW'(prod_im >>> (TW - 2));
    sp_re   = (AW'(a_re) + t_re) >>> 1;
    sp_im   = (AW'(a_im) + t_im) >>> 1;
    sq_re   = (AW'(a_re) - t_re) >>> 1;
    sq_im   = (AW'(a_im) - t_im) >>> 1;
    p_re    = sat(sp_re);
    p_im    = sat(sp_im);
    q_re    = sat(sq_re);
    q_im    = sat(sq_im);
  end

  // Next-state, counters and registered output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bfly_d      = bfly_q;
    stage_d     = stage_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    ld_we       = 1'b0;
    bf_we       = 1'b0;
    cnt_nx      = cnt_q + 1'b1;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          ld_we = 1'b1;
          cnt_d = cnt_nx;
          if (cnt_q == LOG2N'(N - 1)) state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        bf_we  = 1'b1;
        bfly_d = bfly_q + 1'b1;
        if (bfly_q == CW'(HALF - 1)) begin
          stage_d = stage_q + 1'b1;
          if (stage_q == SW'(LOG2N - 1)) begin
            // The last butterfly touches addresses N/2-1 and N-1, never 0,
            // so bin 0 can be taken from the array before that write lands.
            stage_d     = '0;
            state_d     = S_UNLOAD;
            out_valid_d = 1'b1;
            out_re_d    = mem_re_q[0];
            out_im_d    = mem_im_q[0];
            out_index_d = '0;
            out_last_d  = 1'b0;
          end
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          if (cnt_q == LOG2N'(N - 1)) begin
            cnt_d       = '0;
            state_d     = S_LOAD;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            cnt_d       = cnt_nx;
            out_re_d    = mem_re_q[cnt_nx];
            out_im_d    = mem_im_q[cnt_nx];
            out_index_d = cnt_nx;
            out_last_d  = (cnt_nx == LOG2N'(N - 1));
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Control and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      bfly_q      <= '0;
      stage_q     <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bfly_q      <= bfly_d;
      stage_q     <= stage_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  // Sample buffer: bit-reversed load, in-place butterfly write-back.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_re_q[bitrev(cnt_q)] <= in_re;
      mem_im_q[bitrev(cnt_q)] <= in_im;
    end
    if (bf_we) begin
      mem_re_q[addr_p] <= p_re;
      mem_im_q[addr_p] <= p_im;
      mem_re_q[addr_q] <= q_re;
      mem_im_q[addr_q] <= q_im;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
endmodule

// File: doc/fft_r2_seq.md
# fft_r2_seq

Parametrised, sequential radix-2 decimation-in-time FFT core. It accepts N complex samples over a valid/ready stream and computes the transform in place in a register-array buffer, one butterfly per clock. It then streams the N bins out in natural order. It succeeds the fixed 8-point combinational butterfly network, adding runtime-free generalisation in N and data width, complex inputs, per-stage scaling with saturation, and stream flow control.

## Interface
Parameters:
- N, 8, transform length; power of two, 4..1024
- DW, 16, signed sample width, real and imaginary each
- TW, 16, signed twiddle width; value 1.0 = 2^(TW-2)
- LOG2N, derived, log2(N); not overridden by users

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  core accepts an input sample
- in_re, in_im  in  DW  signed input sample, two's complement
- out_valid  out  1  output bin valid
- out_ready  in  1  downstream accepts a bin
- out_re, out_im  out  DW  signed output bin
- out_index  out  LOG2N  bin number k of the current output
- out_last  out  1  high with bin N-1
- busy  out  1  high in COMPUTE and UNLOAD

## Operation
- State machine: LOAD -> COMPUTE -> UNLOAD -> LOAD.
  - LOAD: in_ready=1. Each in_valid&in_ready transfer writes sample n (n counts 0..N-1) to buffer address bitrev(n). After sample N-1 the core enters COMPUTE.
  - COMPUTE: in_ready=0. Runs LOG2N stages s=0..LOG2N-1, each with N/2 butterflies, counter c=0..N/2-1.
    - Butterfly addresses: j=c mod 2^s, g=c>>s, top p=g*2^(s+1)+j, bottom q=p+2^s.
    - Twiddle: W=W_N^k with k=j*(N>>(s+1)), W=cos(2πk/N) - j·sin(2πk/N), held in a ROM of N/2 entries, each entry round-to-nearest of value×2^(TW-2).
    - Butterfly math:
      - t = b·W, full precision, then arithmetic shift right by TW-2 (truncate).
      - p' = (a+t)>>>1 and q' = (a-t)>>>1, computed at DW+2 bits.
      - Results saturate to [-2^(DW-1), 2^(DW-1)-1].
    - Both results are written back in the same cycle; reads are combinational from the register array.
    - After the last butterfly of the last stage the core enters UNLOAD.
  - UNLOAD: presents bin k=0..N-1 from address k.
    - out_re/out_im/out_index are held stable while out_valid&!out_ready.
    - k advances on each out_valid&out_ready.
    - The transfer of k=N-1 (with out_last=1) returns the core to LOAD.
- Net scaling: output = DFT(x)/N, with truncation per stage.
- in_valid is ignored whenever in_ready=0. No sample is lost or double-written under in_valid toggling.
- rst at any time, including mid-COMPUTE or mid-UNLOAD, aborts the frame. The buffer contents are don't-care.

## Timing
- Reset values: in_ready=1 (state LOAD), out_valid=0, out_re=0, out_im=0, out_index=0, out_last=0, busy=0. Sample and butterfly counters are 0.
- in_ready and busy decode directly from the state register.
- The cycle after the N-th input handshake is COMPUTE cycle 0.
- COMPUTE lasts exactly LOG2N·N/2 cycles: 12 for N=8, 5120 for N=1024.
- out_valid rises on the cycle after the last butterfly. Latency from the last input handshake to first out_valid is LOG2N·N/2+1 cycles.
- With out_ready held at 1, bins stream one per cycle, so UNLOAD lasts N cycles.
- in_ready rises the cycle after the out_last handshake. Back-to-back frames have no further gap.
- Every output (out_valid, out_re, out_im, out_index, out_last) is registered.

## Test plan
- N=8, DW=16, TW=16; input impulse x[0]=1024+0j, x[1..7]=0 -> bins 0..7 all 128+0j exactly. COMPUTE lasts 12 cycles; first out_valid arrives 13 cycles after the last input handshake.
- Constant input x[n]=800+0j -> bin 0 = 800+0j, bins 1..7 = 0+0j exactly; out_last is high only at out_index 7.
- x[n]=round(16000·cos(2πn/8)) -> bins 1 and 7 ≈ 8000+0j, within ±2 LSB of a bit-accurate model; other bins within ±2 LSB of 0. Saturation never triggers. Repeat with N=64 and random full-scale complex inputs, compared bit-exact against the same model, including saturation cases.
- Backpressure: out_ready toggles 1,0,0,1 pseudo-randomly -> output data and out_index stay stable while stalled. All 8 bins appear exactly once, in order. in_ready stays 0 until after the out_last handshake.
- in_valid asserted continuously through COMPUTE and UNLOAD -> no extra samples are accepted. The next frame's first sample is captured only on the cycle in_ready returns to 1.
- rst pulsed at COMPUTE cycle 5 and again mid-UNLOAD -> outputs return immediately to their reset values and the state returns to LOAD. A following clean frame produces correct results.
